// File: rtl/mem_pkg.sv
// Shared widths and state/grant encodings for the two-port memory arbiter.
package mem_pkg;

  localparam int ADDR_W = 26;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;
  typedef enum logic {GNT_IC, GNT_DC} mem_grant_t;

  // A latency of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin grant between icache and dcache, remembering the last winner.
module mem_rr_arb2 (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_ic_i,
  input  logic                req_dc_i,
  input  logic                update_i,
  output logic                valid_o,
  output mem_pkg::mem_grant_t grant_o
);
  import mem_pkg::*;

  mem_grant_t last_grant_q;

  assign valid_o = req_ic_i | req_dc_i;

  // On a tie the requester that lost last time wins.
  always_comb begin
    grant_o = GNT_IC;
    if (req_ic_i && req_dc_i) begin
      if (last_grant_q == GNT_IC) begin
        grant_o = GNT_DC;
      end else begin
        grant_o = GNT_IC;
      end
    end else if (req_dc_i) begin
      grant_o = GNT_DC;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= GNT_IC;
    end else if (update_i && valid_o) begin
      last_grant_q <= grant_o;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory front end: arbitrates icache/dcache line requests, drives the RAM for a
// fixed latency and returns one line per transaction with a one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_W      = mem_pkg::ADDR_W,
  parameter int LINE_W      = mem_pkg::LINE_W,
  parameter int MEM_LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_write,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [LINE_W-1:0] mem_rdata
);
  import mem_pkg::*;

  localparam int               CNT_W    = cnt_width(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_t        state_q;
  mem_grant_t        owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q;
  logic              mem_write_q;
  logic              ic_ack_q;
  logic              dc_ack_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] line_q;

  logic       arb_valid;
  mem_grant_t arb_grant;
  logic       arb_update;
  logic       gnt_write;

  assign arb_update = (state_q == IDLE);
  assign gnt_write  = (arb_grant == GNT_DC) && dc_write;

  mem_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_ic_i (ic_req),
    .req_dc_i (dc_req),
    .update_i (arb_update),
    .valid_o  (arb_valid),
    .grant_o  (arb_grant)
  );

  // The write strobe is raised one cycle ahead so it lands on the final BUSY cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= GNT_IC;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      mem_write_q <= 1'b0;
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      line_q      <= '0;
    end else begin
      ic_ack_q    <= 1'b0;
      dc_ack_q    <= 1'b0;
      mem_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            state_q     <= BUSY;
            owner_q     <= arb_grant;
            cnt_q       <= CNT_LOAD;
            wr_q        <= gnt_write;
            mem_addr_q  <= (arb_grant == GNT_DC) ? dc_addr : ic_addr;
            mem_wdata_q <= dc_wdata;
            mem_write_q <= gnt_write && (MEM_LATENCY == 1);
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q  <= RESP;
            ic_ack_q <= (owner_q == GNT_IC);
            dc_ack_q <= (owner_q == GNT_DC);
            if (!wr_q) begin
              line_q <= mem_rdata;
            end
          end else begin
            cnt_q       <= cnt_q - CNT_ONE;
            mem_write_q <= wr_q && (cnt_q == CNT_ONE);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ic_ack    = ic_ack_q;
  assign dc_ack    = dc_ack_q;
  assign ic_rdata  = line_q;
  assign dc_rdata  = line_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory front end between the instruction cache, the data cache and `ram_memory`. It arbitrates line requests from the two caches and drives the RAM's line address, write data and write strobe. It models a fixed main-memory latency and returns one 128-bit line per transaction with a single-cycle acknowledge. It is the only block allowed to drive the RAM's request ports.

## Interface
Parameters:
- `ADDR_W`, 26: line address width; matches the RAM line address.
- `LINE_W`, 128: line width, four 32-bit words.
- `MEM_LATENCY`, 5: cycles spent in BUSY per transaction; must be at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `ic_req`  in  1  icache read request; level, held until `ic_ack`.
- `ic_addr`  in  ADDR_W  icache line address.
- `ic_ack`  out  1  one-cycle pulse; `ic_rdata` is valid in this cycle.
- `ic_rdata`  out  LINE_W  returned line.
- `dc_req`  in  1  dcache request; level, held until `dc_ack`.
- `dc_addr`  in  ADDR_W  dcache line address.
- `dc_write`  in  1  1 = write `dc_wdata`, 0 = read.
- `dc_wdata`  in  LINE_W  line to write.
- `dc_ack`  out  1  one-cycle completion pulse.
- `dc_rdata`  out  LINE_W  returned line; valid on read acks only.
- `mem_addr`  out  ADDR_W  to RAM `data_requested`.
- `mem_wdata`  out  LINE_W  to RAM `data_to_write`.
- `mem_write`  out  1  to RAM `write_to_mem`.
- `mem_rdata`  in  LINE_W  from RAM `data_returned`.

## Operation
- FSM states and transitions:
  - IDLE → BUSY when any request is present.
  - BUSY → RESP after `MEM_LATENCY` cycles.
  - RESP → IDLE always.
- Arbitration happens in IDLE only.
  - If only one request is present, grant it.
  - If both are present, grant the requester not granted last time (`last_grant` bit).
  - `last_grant` resets to IC, so the first tie goes to DC.
- On grant:
  - Latch the address into `mem_addr`, the write flag into `wr_q` and the write data into `mem_wdata`.
  - Record the granted requester.
  - Load the down-counter with `MEM_LATENCY-1`.
  - Update `last_grant`.
- In BUSY:
  - `mem_addr` and `mem_wdata` stay stable.
  - The counter decrements each cycle.
- Final BUSY cycle (counter = 0):
  - Read: capture `mem_rdata` into the line register.
  - Write: assert `mem_write` for exactly this cycle; the line register is not updated.
- In RESP, pulse the ack of the granted requester only. `ic_rdata` and `dc_rdata` both present the line register.
- The icache never writes; `dc_write` is ignored for IC grants.
- A request still high in the IDLE cycle after its ack is a new transaction. Requesters drop `req` on seeing ack unless they are issuing another request.
- Reset (`reset` = 0 at a clock edge), from any state including mid-transaction:
  - State goes to IDLE and the transaction is aborted with no ack.
  - `mem_write` is forced to 0, so an aborted write never reaches the RAM.
  - All outputs go to 0 and `last_grant` goes to IC.

## Timing
- Request sampled in IDLE at cycle 0.
- BUSY occupies cycles 1..`MEM_LATENCY`.
- Ack in cycle `MEM_LATENCY`+1 (6 cycles at the default).
- Earliest next grant is in the following cycle (IDLE).
- Minimum transaction period: `MEM_LATENCY`+2 cycles.
- `mem_write` is high for exactly 1 cycle per write and never outside BUSY.
- All outputs are registered; no combinational path from `*_req` to `*_ack`.
- Counter width: `$clog2(MEM_LATENCY)` bits, minimum 1.

## Structure
- Package `mem_pkg` holds:
  - `ADDR_W` and `LINE_W` constants;
  - `typedef enum {IDLE, BUSY, RESP} mem_state_t`;
  - `typedef enum {GNT_IC, GNT_DC} mem_grant_t`.
- One sub-module is natural: `mem_rr_arb2`, a 2-way round-robin grant with a `last_grant` register and an update enable. The FSM and counter stay in `mem_arbiter`.

## Test plan
All scenarios use the default `MEM_LATENCY`=5 and the RAM's reset contents (word i = i).

1. Reset: hold `reset`=0 for 2 cycles with both requests high → all outputs 0, `mem_write` 0, no ack within 10 cycles of holding reset.
2. `ic_req`, `ic_addr`=3 → `ic_ack` pulses in cycle 6; `ic_rdata` = 128'h0000000F_0000000E_0000000D_0000000C; `dc_ack` stays 0.
3. DC write, addr 2, wdata 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0 → `mem_write` high only in cycle 5, `dc_ack` in cycle 6. A following DC read of addr 2 returns the written line.
4. `ic_req` and `dc_req` rise together at cycle 0:
   - DC is granted; `dc_ack` at cycle 6.
   - IC is granted at cycle 7; `ic_ack` at cycle 13.
5. Both requests held continuously (re-asserted after each ack) → grant order DC, IC, DC, IC; acks 7 cycles apart.
6. DC write to addr 4 with `reset`=0 during the 3rd BUSY cycle → `mem_write` never asserted, no `dc_ack`, line 4 reads back as 128'h00000013_00000012_00000011_00000010.
